// File: rtl/grf_pkg.sv
// Shared register-file types and sizes for the writeback path.
// Also used by the mult/div and load units for their writeback payloads.
package grf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     pc;
  } wb_req_t;

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Writeback request bundle: N_REQ packed requesters with valid/ready handshake.
// The master side is the set of producers; the slave side is the arbiter.
interface grf_wb_arbiter_if
  import grf_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) ();

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*REG_ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0]     req_data;
  logic [N_REQ*DATA_W-1:0]     req_pc;
  logic [N_REQ-1:0]            req_ready;

  modport master (
    output req_valid, req_addr, req_data, req_pc,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_pc,
    output req_ready
  );

endinterface

// File: rtl/grf_wb_arbiter_rr.sv
// Combinational round-robin arbiter: first request at or after ptr wins,
// wrapping to index 0. Pointer state lives in the instantiating block.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt_c
);

  logic found;

  // Upper pass covers ptr..N-1, lower pass wraps around to 0..ptr-1.
  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
        gnt_c[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt_c[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the register-file write port between writeback sources via round-robin,
// registering the winner into a one-entry commit stage that also feeds forwarding.
module grf_wb_arbiter
  import grf_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  grf_wb_arbiter_if.slave       req_if,
  output logic                  grf_we,
  output logic [REG_ADDR_W-1:0] grf_waddr,
  output logic [DATA_W-1:0]     grf_wdata,
  output logic [DATA_W-1:0]     grf_pc,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      commit_cnt,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NEL_W = $clog2(N_REQ + 1);

  wb_req_t          req_w [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] zero_addr;
  logic [N_REQ-1:0] gnt;
  logic [NEL_W-1:0] n_elig;
  logic [PTR_W-1:0] win;

  logic [PTR_W-1:0] rr_q, rr_d;
  logic             we_q, we_d;
  wb_req_t          commit_q, commit_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  // Unpack requesters; writes to $0 are acked directly and never arbitrate.
  always_comb begin
    elig      = '0;
    zero_addr = '0;
    n_elig    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_w[i].addr = req_if.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
      req_w[i].data = req_if.req_data[i*DATA_W +: DATA_W];
      req_w[i].pc   = req_if.req_pc[i*DATA_W +: DATA_W];
      elig[i]       = req_if.req_valid[i] && (req_w[i].addr != '0);
      zero_addr[i]  = req_if.req_valid[i] && (req_w[i].addr == '0);
      n_elig        = n_elig + NEL_W'(elig[i]);
    end
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (elig),
    .ptr   (rr_q),
    .gnt_c (gnt)
  );

  assign req_if.req_ready = reset ? '0 : (gnt | zero_addr);

  always_comb begin
    win            = '0;
    rr_d           = rr_q;
    we_d           = 1'b0;
    commit_d       = commit_q;
    commit_cnt_d   = commit_cnt_q + CNT_W'(we_q);
    conflict_cnt_d = conflict_cnt_q + CNT_W'(n_elig >= NEL_W'(2));
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win = PTR_W'(i);
    end
    if (|gnt) begin
      we_d     = 1'b1;
      commit_d = req_w[win];
      rr_d     = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

  // Synchronous reset drops any write still pending in the commit stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q           <= '0;
      we_q           <= 1'b0;
      commit_q       <= '0;
      commit_cnt_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_q           <= rr_d;
      we_q           <= we_d;
      commit_q       <= commit_d;
      commit_cnt_q   <= commit_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grf_we       = we_q;
  assign grf_waddr    = commit_q.addr;
  assign grf_wdata    = commit_q.data;
  assign grf_pc       = commit_q.pc;
  assign fwd_valid    = we_q;
  assign fwd_addr     = commit_q.addr;
  assign fwd_data     = commit_q.data;
  assign commit_cnt   = commit_cnt_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: reference round-robin model feeds an expected-commit
// queue that is drained against grf_*/fwd_* each cycle, plus per-scenario checks.
module tb_grf_wb_arbiter;
  import grf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        grf_we, fwd_valid;
  logic [4:0]  grf_waddr, fwd_addr;
  logic [31:0] grf_wdata, grf_pc, fwd_data;
  logic [31:0] commit_cnt, conflict_cnt;

  grf_wb_arbiter_if #(.N_REQ(3)) rif ();

  grf_wb_arbiter #(.N_REQ(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .req_if(rif),
    .grf_we(grf_we), .grf_waddr(grf_waddr), .grf_wdata(grf_wdata), .grf_pc(grf_pc),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .commit_cnt(commit_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_rr = 0;
  int          m_cc = 0;
  int          m_cf = 0;
  logic        m_we = 1'b0;
  wb_req_t     exp_q [$];
  logic        mon_en = 1'b0;
  logic        pend_we = 1'b0;
  logic [4:0]  pend_a = '0;
  logic [31:0] pend_d = '0;

  logic [31:0] rf     [32];
  logic [31:0] ref_rf [32];

  // Register file driven by the DUT port; shares the synchronous reset so a
  // write dropped by reset never lands.
  always @(posedge clk) if (!reset && grf_we) rf[grf_waddr] <= grf_wdata;
  always @(posedge clk) if (!reset && pend_we) ref_rf[pend_a] <= pend_d;

  // Scoreboard drain: one expected commit per grant, visible the cycle after.
  always @(negedge clk) begin
    if (mon_en) begin
      wb_req_t e;
      total++;
      if (fwd_valid !== grf_we || fwd_addr !== grf_waddr || fwd_data !== grf_wdata) begin
        bad++;
        $display("FAIL fwd_eq: fwd=%b/%0d/%h grf=%b/%0d/%h", fwd_valid, fwd_addr, fwd_data,
                 grf_we, grf_waddr, grf_wdata);
      end
      total++;
      pend_we = 1'b0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (grf_we !== 1'b1 || grf_waddr !== e.addr || grf_wdata !== e.data || grf_pc !== e.pc) begin
          bad++;
          $display("FAIL commit: got we=%b a=%0d d=%h pc=%h want we=1 a=%0d d=%h pc=%h",
                   grf_we, grf_waddr, grf_wdata, grf_pc, e.addr, e.data, e.pc);
        end
        pend_we = 1'b1;
        pend_a  = e.addr;
        pend_d  = e.data;
      end else if (grf_we !== 1'b0) begin
        bad++;
        $display("FAIL idle_we: got we=%b want 0", grf_we);
      end
      total++;
      if (commit_cnt !== 32'(m_cc) || conflict_cnt !== 32'(m_cf)) begin
        bad++;
        $display("FAIL counters: got commit=%0d conflict=%0d want %0d %0d",
                 commit_cnt, conflict_cnt, m_cc, m_cf);
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] p);
    rif.req_valid[i]       = v;
    rif.req_addr[i*5 +: 5]  = a;
    rif.req_data[i*32 +: 32] = d;
    rif.req_pc[i*32 +: 32]   = p;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  // One clock cycle: predict ready from the model, check it, advance the model.
  task automatic tick(output logic [2:0] exp_rdy, output logic [2:0] obs_rdy);
    logic [2:0] ev, zv, gv;
    logic [4:0] a;
    int g, nel;
    wb_req_t e;
    #1;
    ev = '0; zv = '0; nel = 0; g = -1;
    for (int i = 0; i < 3; i++) begin
      a = rif.req_addr[i*5 +: 5];
      if (rif.req_valid[i] && a != 5'd0) begin ev[i] = 1'b1; nel++; end
      if (rif.req_valid[i] && a == 5'd0) zv[i] = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_rr + k) % 3;
      if (g < 0 && ev[idx]) g = idx;
    end
    gv      = (g >= 0) ? 3'(1 << g) : 3'b000;
    exp_rdy = reset ? 3'b000 : (gv | zv);
    obs_rdy = rif.req_ready;
    total++;
    if (obs_rdy !== exp_rdy) begin
      bad++;
      $display("FAIL ready: got %b want %b (rr=%0d)", obs_rdy, exp_rdy, m_rr);
    end
    @(posedge clk);
    if (reset) begin
      m_rr = 0; m_cc = 0; m_cf = 0; m_we = 1'b0;
      exp_q.delete();
    end else begin
      if (m_we) m_cc++;
      if (nel >= 2) m_cf++;
      m_we = (g >= 0);
      if (g >= 0) begin
        e.addr = rif.req_addr[g*5 +: 5];
        e.data = rif.req_data[g*32 +: 32];
        e.pc   = rif.req_pc[g*32 +: 32];
        exp_q.push_back(e);
        m_rr = (g + 1) % 3;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic [2:0] er, orr;
    reset = 1'b1;
    tick(er, orr);
    tick(er, orr);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] er, orr;
    reset = 1'b1;
    set_req(0, 1'b1, 5'd0, 32'h1, 32'h10);
    set_req(1, 1'b1, 5'd5, 32'h2, 32'h20);
    tick(er, orr);
    mon_en = 1'b1;
    tick(er, orr);
    total++;
    if (orr !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", orr); end
    total++;
    if (grf_we !== 1'b0 || grf_waddr !== 5'd0 || grf_wdata !== 32'd0 || grf_pc !== 32'd0) begin
      bad++;
      $display("FAIL reset_grf: got %b %0d %h %h want all 0", grf_we, grf_waddr, grf_wdata, grf_pc);
    end
    total++;
    if (commit_cnt !== 32'd0 || conflict_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d %0d want 0 0", commit_cnt, conflict_cnt);
    end
    clear_all();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [2:0] er, orr;
    do_reset();
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h3000);
    tick(er, orr);
    total++;
    if (orr !== 3'b010) begin bad++; $display("FAIL single_ready: got %b want 010", orr); end
    clear_all();
    total++;
    if (grf_we !== 1'b1 || grf_waddr !== 5'd5 || grf_wdata !== 32'hDEADBEEF || grf_pc !== 32'h3000) begin
      bad++;
      $display("FAIL single_grf: got %b %0d %h %h want 1 5 deadbeef 3000", grf_we, grf_waddr, grf_wdata, grf_pc);
    end
    tick(er, orr);
    total++;
    if (rf[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rf: got %h want deadbeef", rf[5]); end
    total++;
    if (commit_cnt !== 32'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", commit_cnt); end
  endtask

  task automatic test_contention();
    logic [2:0] er, orr;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(i + 1), 32'(100 + i), 32'(32'h400 + 4 * i));
    for (int k = 0; k < 6; k++) begin
      tick(er, orr);
      total++;
      if (orr !== 3'(1 << (k % 3))) begin
        bad++;
        $display("FAIL rr_order: step %0d got %b want %b", k, orr, 3'(1 << (k % 3)));
      end
      set_req(k % 3, 1'b1, 5'((k % 3) + 1), 32'(200 + k), 32'(32'h800 + 4 * k));
    end
    total++;
    if (conflict_cnt !== 32'd6) begin bad++; $display("FAIL conflict_cnt: got %0d want 6", conflict_cnt); end
    clear_all();
    tick(er, orr);
  endtask

  task automatic test_zero_addr();
    logic [2:0] er, orr;
    do_reset();
    set_req(0, 1'b1, 5'd0, 32'h55, 32'h500);
    set_req(2, 1'b1, 5'd7, 32'h77, 32'h700);
    tick(er, orr);
    total++;
    if (orr !== 3'b101) begin bad++; $display("FAIL zero_ready: got %b want 101", orr); end
    clear_all();
    tick(er, orr);
    tick(er, orr);
    total++;
    if (commit_cnt !== 32'd1) begin bad++; $display("FAIL zero_cnt: got %0d want 1", commit_cnt); end
    total++;
    if (rf[7] !== 32'h77 || rf[0] !== 32'h0) begin
      bad++;
      $display("FAIL zero_rf: got r7=%h r0=%h want 77 0", rf[7], rf[0]);
    end
  endtask

  task automatic test_collision();
    logic [2:0] er, orr;
    do_reset();
    set_req(0, 1'b1, 5'd9, 32'h11, 32'h900);
    set_req(1, 1'b1, 5'd9, 32'h22, 32'h904);
    tick(er, orr);
    total++;
    if (orr !== 3'b001) begin bad++; $display("FAIL coll_first: got %b want 001", orr); end
    set_req(0, 1'b0, 5'd0, 32'd0, 32'd0);
    tick(er, orr);
    total++;
    if (orr !== 3'b010) begin bad++; $display("FAIL coll_second: got %b want 010", orr); end
    total++;
    if (rf[9] !== 32'h11) begin bad++; $display("FAIL coll_mid: got %h want 11", rf[9]); end
    clear_all();
    tick(er, orr);
    tick(er, orr);
    total++;
    if (rf[9] !== 32'h22) begin bad++; $display("FAIL coll_final: got %h want 22", rf[9]); end
  endtask

  task automatic test_mid_reset();
    logic [2:0] er, orr;
    do_reset();
    set_req(2, 1'b1, 5'd4, 32'hCAFE, 32'h4000);
    tick(er, orr);
    clear_all();
    total++;
    if (grf_we !== 1'b1) begin bad++; $display("FAIL midrst_pend: got we=%b want 1", grf_we); end
    reset = 1'b1;
    set_req(0, 1'b1, 5'd0, 32'h1, 32'h1);
    set_req(1, 1'b1, 5'd6, 32'h2, 32'h2);
    tick(er, orr);
    total++;
    if (orr !== 3'b000) begin bad++; $display("FAIL midrst_ready: got %b want 000", orr); end
    total++;
    if (grf_we !== 1'b0 || commit_cnt !== 32'd0 || conflict_cnt !== 32'd0) begin
      bad++;
      $display("FAIL midrst_state: got we=%b cc=%0d cf=%0d want 0 0 0", grf_we, commit_cnt, conflict_cnt);
    end
    total++;
    if (rf[4] !== 32'h0) begin bad++; $display("FAIL midrst_rf: got %h want 0", rf[4]); end
    reset = 1'b0;
    clear_all();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(i + 10), 32'(i), 32'(i));
    tick(er, orr);
    total++;
    if (orr !== 3'b001) begin bad++; $display("FAIL midrst_rr: got %b want 001", orr); end
    clear_all();
    tick(er, orr);
  endtask

  task automatic test_random();
    logic [2:0] er, orr;
    logic [2:0] v = '0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom, $urandom);
        end
      end
      tick(er, orr);
      for (int i = 0; i < 3; i++) begin
        if (er[i]) begin
          v[i] = 1'b0;
          set_req(i, 1'b0, 5'd0, 32'd0, 32'd0);
        end
      end
    end
    clear_all();
    tick(er, orr);
    tick(er, orr);
    for (int r = 0; r < 32; r++) begin
      total++;
      if (rf[r] !== ref_rf[r]) begin
        bad++;
        $display("FAIL rf_model: reg %0d got %h want %h", r, rf[r], ref_rf[r]);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      rf[r]     = 32'd0;
      ref_rf[r] = 32'd0;
    end
    reset = 1'b1;
    clear_all();
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_zero_addr();
    test_collision();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
